tb_mmio_ctrl: RTL and testbench

- Synthesisable memory-mapped test-control peripheral on the core data bus (OBI-style slave).
- Parametrised successor of the testbench exit/print/cycle-counter logic, now a standalone block.
- Adds:
  - 64-bit cycle counter with coherent hi/lo reads
  - buffered character output stream with backpressure
  - programmable watchdog that forces an exit
  - status register
- Instantiated between the core's data port and the top-level address decoder; the bench consumes the exit_* and char_* outputs.

---
 rtl/tb_mmio_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_tb_mmio_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_ctrl
// Memory-mapped test-control peripheral sitting on the core data bus as an
// OBI-style slave. It gives software a way to end the simulation with an exit
// code, to stream characters out to the bench, to read a 64-bit cycle counter
// coherently as two 32-bit halves, and to arm a watchdog that forces an exit.
//
// Register window (64 bytes at BASE_ADDR, word offsets):
//   0x00 EXIT      W: set sticky exit with code     R: cycle[31:0]
//   0x04 PRINT     W (be[0]): push wdata[7:0]       R: 0
//   0x08 CYCLE_LO  R: cycle[31:0], snapshots the high half
//   0x0C CYCLE_HI  R: snapshotted high half
//   0x10 TIMEOUT   W: load watchdog (0 = off)       R: remaining count
//   0x14 STATUS    R: {level[15:8], empty[2], full[1], exit[0]}
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_i, addr_i, we_i, be_i, wdata_i   bus request channel
//   gnt_o                combinational grant
//   rvalid_o, rdata_o    registered response, one cycle after grant
//   char_valid_o, char_data_o, char_ready_i   character stream out
//   exit_valid_o, exit_code_o                 sticky exit request
// -----------------------------------------------------------------------------
module tb_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CNT_W        = 64,
  parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        exit_valid_o,
  output logic [31:0] exit_code_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int HI_W  = CNT_W - 32;

  localparam logic [PTR_W:0]   DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [3:0] OFF_EXIT     = 4'd0;
  localparam logic [3:0] OFF_PRINT    = 4'd1;
  localparam logic [3:0] OFF_CYCLE_LO = 4'd2;
  localparam logic [3:0] OFF_CYCLE_HI = 4'd3;
  localparam logic [3:0] OFF_TIMEOUT  = 4'd4;
  localparam logic [3:0] OFF_STATUS   = 4'd5;

  logic             in_window;
  logic [3:0]       reg_sel;
  logic [CNT_W-1:0] cycle;
  logic [HI_W-1:0]  hi_shadow;
  logic [31:0]      watchdog;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   level;
  logic             full;
  logic             empty;
  logic             print_wr;
  logic             gnt;
  logic             push;
  logic             pop;
  logic             exit_wr;
  logic             timeout_wr;
  logic             expire;
  logic [31:0]      rd_value;
  logic             unused_bits;

  assign unused_bits = ^{addr_i[1:0], be_i[3:1]};

  assign in_window = (addr_i[31:6] == BASE_ADDR[31:6]);
  assign reg_sel   = addr_i[5:2];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  // A PRINT write stalls on a full FIFO even if the sink pops this cycle;
  // the freed slot is only offered from the next cycle on.
  assign print_wr   = we_i && (reg_sel == OFF_PRINT);
  assign gnt        = rst_ni && req_i && in_window && !(print_wr && full);
  assign gnt_o      = gnt;

  assign push       = gnt && print_wr && be_i[0];
  assign pop        = !empty && char_ready_i;
  assign exit_wr    = gnt && we_i && (reg_sel == OFF_EXIT);
  assign timeout_wr = gnt && we_i && (reg_sel == OFF_TIMEOUT);

  // A TIMEOUT write replaces the decrement, so it also cancels a pending expiry.
  assign expire = (watchdog == 32'd1) && !timeout_wr;

  assign char_valid_o = !empty;
  assign char_data_o  = empty ? 8'h00 : fifo_mem[rd_ptr[PTR_W-1:0]];

  // Read data for the current request, sampled in the grant cycle so counter
  // reads see the pre-increment value. Writes and unmapped offsets read zero.
  always_comb begin
    rd_value = '0;
    if (!we_i) begin
      case (reg_sel)
        OFF_EXIT:     rd_value = cycle[31:0];
        OFF_CYCLE_LO: rd_value = cycle[31:0];
        OFF_CYCLE_HI: rd_value[HI_W-1:0] = hi_shadow;
        OFF_TIMEOUT:  rd_value = watchdog;
        OFF_STATUS: begin
          rd_value[0]             = exit_valid_o;
          rd_value[1]             = full;
          rd_value[2]             = empty;
          rd_value[8 +: PTR_W+1]  = level;
        end
        default:      rd_value = '0;
      endcase
    end
  end

  // Main state: bus response, cycle counter, hi snapshot, watchdog, sticky
  // exit and FIFO pointers. Reset wins over any in-flight request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_o     <= 1'b0;
      rdata_o      <= '0;
      cycle        <= '0;
      hi_shadow    <= '0;
      watchdog     <= '0;
      exit_valid_o <= 1'b0;
      exit_code_o  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      cycle    <= cycle + CNT_ONE;
      rvalid_o <= gnt;
      rdata_o  <= gnt ? rd_value : 32'h0;

      if (gnt && !we_i && (reg_sel == OFF_CYCLE_LO)) begin
        hi_shadow <= cycle[CNT_W-1:32];
      end

      if (timeout_wr) begin
        watchdog <= wdata_i;
      end else if (watchdog != 32'd0) begin
        watchdog <= watchdog - 32'd1;
      end

      // Software exit beats a simultaneous watchdog expiry.
      if (!exit_valid_o) begin
        if (exit_wr) begin
          exit_valid_o <= 1'b1;
          exit_code_o  <= wdata_i;
        end else if (expire) begin
          exit_valid_o <= 1'b1;
          exit_code_o  <= TIMEOUT_CODE;
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Character storage needs no reset: entries are only visible between the
  // pointers, and reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= wdata_i[7:0];
    end
  end

endmodule

// File: tb/tb_tb_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tb_mmio_ctrl
// Self-checking bench for tb_mmio_ctrl. A single process drives the bus and,
// once per cycle at the falling edge, updates a behavioural model: a queue of
// pending characters, a free-running cycle count and the expected grant.
// Each test task drives its own scenario and compares against the model.
// -----------------------------------------------------------------------------
module tb_tb_mmio_ctrl;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          DEPTH   = 8;
  localparam logic [31:0] TO_CODE = 32'hDEAD_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        exit_valid;
  logic [31:0] exit_code;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  q[$];
  logic [7:0]  emitted[$];
  logic [63:0] tb_cycle = '0;
  logic [63:0] cyc_snap;
  logic [63:0] gnt_cyc;
  int          lvl_snap;
  int          gnt_lvl;
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  tb_mmio_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .addr_i       (addr),
    .we_i         (we),
    .be_i         (be),
    .wdata_i      (wdata),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .char_valid_o (char_valid),
    .char_data_o  (char_data),
    .char_ready_i (char_ready),
    .exit_valid_o (exit_valid),
    .exit_code_o  (exit_code)
  );

  function automatic logic in_win(input logic [31:0] a);
    return a[31:6] == BASE[31:6];
  endfunction

  // One clock cycle: at the falling edge check grant and the character stream
  // against the model and advance it; after the rising edge check rvalid.
  task automatic tick(output logic g);
    logic       r;
    logic       exp_g;
    logic [3:0] off;
    @(negedge clk);
    g     = gnt;
    r     = rst_n;
    off   = addr[5:2];
    exp_g = req && r && in_win(addr) && !(we && off == 4'd1 && q.size() == DEPTH);
    n_checks++;
    if (g !== exp_g) begin
      n_fail++;
      $display("[TB] FAIL gnt: got %b expected %b (addr %h we %b level %0d)", g, exp_g, addr, we, q.size());
    end
    cyc_snap = tb_cycle;
    lvl_snap = q.size();
    if (!r) begin
      q.delete();
      tb_cycle = '0;
    end else begin
      n_checks++;
      if (char_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("[TB] FAIL char_valid: got %b expected %b", char_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_checks++;
        if (char_data !== q[0]) begin
          n_fail++;
          $display("[TB] FAIL char_data: got %h expected %h", char_data, q[0]);
        end
        if (char_ready) emitted.push_back(q.pop_front());
      end
      if (g && we && off == 4'd1 && be[0]) q.push_back(wdata[7:0]);
      tb_cycle++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rvalid !== (g && r)) begin
      n_fail++;
      $display("[TB] FAIL rvalid: got %b expected %b", rvalid, g && r);
    end
    if (rand_ready) char_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    logic g;
    for (int i = 0; i < n; i++) tick(g);
  endtask

  // Issue one request and hold it until granted (bounded); returns the
  // response data and the number of stalled cycles.
  task automatic bus_xfer(input logic wr, input logic [5:0] off, input logic [3:0] bmask,
                          input logic [31:0] d, output logic [31:0] rd, output int waits);
    logic g;
    req   = 1'b1;
    we    = wr;
    addr  = BASE + {26'b0, off};
    be    = bmask;
    wdata = d;
    waits = 0;
    rd    = '0;
    forever begin
      tick(g);
      if (g) begin
        rd      = rdata;
        gnt_cyc = cyc_snap;
        gnt_lvl = lvl_snap;
        break;
      end
      waits++;
      if (waits > 40) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL grant timeout: got no gnt expected gnt within 40 cycles (addr %h)", addr);
        break;
      end
    end
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req        = 1'b0;
    we         = 1'b0;
    char_ready = 1'b0;
    rand_ready = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    emitted.delete();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int          w;
    do_reset();
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset rdata: got %h expected 0", rdata); end
    n_checks++; if (char_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset char_valid: got %b expected 0", char_valid); end
    n_checks++; if (char_data !== 8'h0) begin n_fail++; $display("[TB] FAIL reset char_data: got %h expected 0", char_data); end
    n_checks++; if (exit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset exit_valid: got %b expected 0", exit_valid); end
    n_checks++; if (exit_code !== 32'h0) begin n_fail++; $display("[TB] FAIL reset exit_code: got %h expected 0", exit_code); end
    bus_xfer(1'b0, 6'h14, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'h4) begin n_fail++; $display("[TB] FAIL reset status: got %h expected 00000004", rd); end
    bus_xfer(1'b0, 6'h10, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL reset timeout: got %h expected 0", rd); end
  endtask

  task automatic test_exit();
    logic [31:0] rd;
    int          w;
    do_reset();
    bus_xfer(1'b1, 6'h00, 4'hF, 32'h0, rd, w);
    n_checks++; if (w !== 0) begin n_fail++; $display("[TB] FAIL exit gnt latency: got %0d expected 0", w); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL exit write rdata: got %h expected 0", rd); end
    n_checks++; if (exit_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL exit valid: got %b expected 1", exit_valid); end
    n_checks++; if (exit_code !== 32'h0) begin n_fail++; $display("[TB] FAIL exit code: got %h expected 0", exit_code); end
    bus_xfer(1'b1, 6'h00, 4'hF, 32'd5, rd, w);
    bus_xfer(1'b1, 6'h10, 4'hF, 32'd3, rd, w);
    idle(8);
    n_checks++; if (exit_code !== 32'h0) begin n_fail++; $display("[TB] FAIL exit sticky code: got %h expected 0", exit_code); end
    bus_xfer(1'b0, 6'h14, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("[TB] FAIL exit status: got %h expected 00000005", rd); end
    do_reset();
    bus_xfer(1'b1, 6'h00, 4'h1, 32'h1234_5678, rd, w);
    n_checks++; if (exit_code !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL exit full word: got %h expected 12345678", exit_code); end
  endtask

  task automatic test_print_hi();
    logic [31:0] rd;
    int          w;
    do_reset();
    char_ready = 1'b1;
    bus_xfer(1'b1, 6'h04, 4'h1, 32'h48, rd, w);
    bus_xfer(1'b1, 6'h04, 4'h1, 32'h49, rd, w);
    idle(4);
    n_checks++; if (emitted.size() !== 2) begin n_fail++; $display("[TB] FAIL print count: got %0d expected 2", emitted.size()); end
    if (emitted.size() == 2) begin
      n_checks++; if (emitted[0] !== 8'h48) begin n_fail++; $display("[TB] FAIL print first: got %h expected 48", emitted[0]); end
      n_checks++; if (emitted[1] !== 8'h49) begin n_fail++; $display("[TB] FAIL print second: got %h expected 49", emitted[1]); end
    end
    bus_xfer(1'b0, 6'h14, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'h4) begin n_fail++; $display("[TB] FAIL print status: got %h expected 00000004", rd); end
    bus_xfer(1'b1, 6'h04, 4'hE, 32'h5A, rd, w);
    idle(3);
    n_checks++; if (emitted.size() !== 2) begin n_fail++; $display("[TB] FAIL print be0 off: got %0d chars expected 2", emitted.size()); end
    bus_xfer(1'b0, 6'h04, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL print read: got %h expected 0", rd); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] rd;
    int          w;
    logic        g;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      bus_xfer(1'b1, 6'h04, 4'h1, 32'h41 + i, rd, w);
      n_checks++; if (w !== 0) begin n_fail++; $display("[TB] FAIL fill stall %0d: got %0d expected 0", i, w); end
    end
    bus_xfer(1'b0, 6'h14, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'h0802) begin n_fail++; $display("[TB] FAIL full status: got %h expected 00000802", rd); end
    req = 1'b1; we = 1'b1; addr = BASE + 32'h4; be = 4'h1; wdata = 32'h39;
    for (int i = 0; i < 3; i++) begin
      tick(g);
      n_checks++; if (g !== 1'b0) begin n_fail++; $display("[TB] FAIL full stall: got gnt %b expected 0", g); end
    end
    char_ready = 1'b1;
    tick(g);
    n_checks++; if (g !== 1'b0) begin n_fail++; $display("[TB] FAIL pop same cycle: got gnt %b expected 0", g); end
    char_ready = 1'b0;
    tick(g);
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("[TB] FAIL after pop: got gnt %b expected 1", g); end
    req = 1'b0; we = 1'b0;
    bus_xfer(1'b0, 6'h14, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'h0802) begin n_fail++; $display("[TB] FAIL refill status: got %h expected 00000802", rd); end
    char_ready = 1'b1;
    idle(12);
    n_checks++; if (emitted.size() !== DEPTH + 1) begin n_fail++; $display("[TB] FAIL drain count: got %0d expected %0d", emitted.size(), DEPTH + 1); end
    if (emitted.size() == DEPTH + 1) begin
      n_checks++; if (emitted[DEPTH] !== 8'h39) begin n_fail++; $display("[TB] FAIL drain last: got %h expected 39", emitted[DEPTH]); end
    end
  endtask

  task automatic test_cycle();
    logic [31:0] rd;
    logic [63:0] n;
    int          w;
    logic        g;
    do_reset();
    idle(int'($urandom_range(3, 20)));
    bus_xfer(1'b0, 6'h08, 4'hF, 32'h0, rd, w);
    n = gnt_cyc;
    n_checks++; if (rd !== n[31:0]) begin n_fail++; $display("[TB] FAIL cycle lo: got %h expected %h", rd, n[31:0]); end
    idle(5);
    bus_xfer(1'b0, 6'h0C, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== n[63:32]) begin n_fail++; $display("[TB] FAIL cycle hi: got %h expected %h", rd, n[63:32]); end
    bus_xfer(1'b0, 6'h00, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== gnt_cyc[31:0]) begin n_fail++; $display("[TB] FAIL exit read cycle: got %h expected %h", rd, gnt_cyc[31:0]); end
    bus_xfer(1'b0, 6'h08, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== gnt_cyc[31:0]) begin n_fail++; $display("[TB] FAIL cycle lo b2b: got %h expected %h", rd, gnt_cyc[31:0]); end
    req = 1'b1; we = 1'b0; addr = BASE + 32'h40;
    tick(g);
    n_checks++; if (g !== 1'b0) begin n_fail++; $display("[TB] FAIL out of window: got gnt %b expected 0", g); end
    req = 1'b0;
    bus_xfer(1'b1, 6'h3C, 4'hF, 32'hFFFF_FFFF, rd, w);
    bus_xfer(1'b0, 6'h3C, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL unmapped read: got %h expected 0", rd); end
  endtask

  task automatic test_watchdog();
    logic [31:0] rd;
    logic [63:0] cw;
    int          w;
    int          k;
    logic        g;
    do_reset();
    bus_xfer(1'b1, 6'h10, 4'hF, 32'd100, rd, w);
    cw = gnt_cyc;
    for (int i = 0; i < 2; i++) begin
      bus_xfer(1'b0, 6'h10, 4'hF, 32'h0, rd, w);
      n_checks++;
      if (rd !== 32'(100 - (gnt_cyc - cw - 1))) begin
        n_fail++; $display("[TB] FAIL timeout remaining: got %0d expected %0d", rd, 100 - (gnt_cyc - cw - 1));
      end
    end
    bus_xfer(1'b1, 6'h10, 4'hF, 32'd0, rd, w);
    idle(120);
    n_checks++; if (exit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL watchdog disabled: got exit %b expected 0", exit_valid); end
    bus_xfer(1'b1, 6'h10, 4'hF, 32'd10, rd, w);
    k = 0;
    while (exit_valid !== 1'b1 && k < 40) begin
      tick(g);
      k++;
    end
    n_checks++; if (k !== 10) begin n_fail++; $display("[TB] FAIL watchdog delay: got %0d cycles expected 10", k); end
    n_checks++; if (exit_code !== TO_CODE) begin n_fail++; $display("[TB] FAIL watchdog code: got %h expected %h", exit_code, TO_CODE); end
    bus_xfer(1'b1, 6'h00, 4'hF, 32'd7, rd, w);
    n_checks++; if (exit_code !== TO_CODE) begin n_fail++; $display("[TB] FAIL watchdog sticky: got %h expected %h", exit_code, TO_CODE); end
    // Expiry coincides with the EXIT write granted right after a load of 1.
    do_reset();
    bus_xfer(1'b1, 6'h10, 4'hF, 32'd1, rd, w);
    bus_xfer(1'b1, 6'h00, 4'hF, 32'h55, rd, w);
    n_checks++; if (exit_code !== 32'h55) begin n_fail++; $display("[TB] FAIL exit vs expiry: got %h expected 00000055", exit_code); end
    // A reload while counting down takes priority over the decrement.
    do_reset();
    bus_xfer(1'b1, 6'h10, 4'hF, 32'd2, rd, w);
    bus_xfer(1'b1, 6'h10, 4'hF, 32'd5, rd, w);
    bus_xfer(1'b0, 6'h10, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'd5) begin n_fail++; $display("[TB] FAIL reload wins: got %0d expected 5", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] exp;
    logic [63:0] n;
    logic [5:0]  off;
    int          w;
    logic        g;
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: begin
          bus_xfer(1'b1, 6'h04, 4'($urandom_range(0, 15)), $urandom, rd, w);
          n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL rand write rdata: got %h expected 0", rd); end
        end
        1: begin
          bus_xfer(1'b0, 6'h14, 4'hF, 32'h0, rd, w);
          exp = {16'h0, 8'(gnt_lvl), 5'b0, gnt_lvl == 0, gnt_lvl == DEPTH, 1'b0};
          n_checks++; if (rd !== exp) begin n_fail++; $display("[TB] FAIL rand status: got %h expected %h", rd, exp); end
        end
        2: begin
          bus_xfer(1'b0, 6'h08, 4'hF, 32'h0, rd, w);
          n = gnt_cyc;
          n_checks++; if (rd !== n[31:0]) begin n_fail++; $display("[TB] FAIL rand cycle lo: got %h expected %h", rd, n[31:0]); end
          bus_xfer(1'b0, 6'h0C, 4'hF, 32'h0, rd, w);
          n_checks++; if (rd !== n[63:32]) begin n_fail++; $display("[TB] FAIL rand cycle hi: got %h expected %h", rd, n[63:32]); end
        end
        3: tick(g);
        default: begin
          off = 6'(24 + 4 * $urandom_range(0, 9));
          bus_xfer(1'b0, off, 4'hF, 32'h0, rd, w);
          n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL rand unmapped %h: got %h expected 0", off, rd); end
        end
      endcase
    end
    rand_ready = 1'b0;
    char_ready = 1'b1;
    idle(12);
    n_checks++; if (char_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rand drained: got char_valid %b expected 0", char_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int          w;
    logic        g;
    do_reset();
    for (int i = 0; i < 3; i++) bus_xfer(1'b1, 6'h04, 4'h1, 32'h61 + i, rd, w);
    bus_xfer(1'b1, 6'h00, 4'hF, 32'd7, rd, w);
    bus_xfer(1'b0, 6'h14, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'h0301) begin n_fail++; $display("[TB] FAIL pre-reset status: got %h expected 00000301", rd); end
    req = 1'b1; we = 1'b0; addr = BASE + 32'h14;
    tick(g);
    rst_n = 1'b0;
    tick(g);
    n_checks++; if (g !== 1'b0) begin n_fail++; $display("[TB] FAIL reset gnt: got %b expected 0", g); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL mid reset rdata: got %h expected 0", rdata); end
    n_checks++; if (char_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid reset char_valid: got %b expected 0", char_valid); end
    n_checks++; if (char_data !== 8'h0) begin n_fail++; $display("[TB] FAIL mid reset char_data: got %h expected 0", char_data); end
    n_checks++; if (exit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid reset exit_valid: got %b expected 0", exit_valid); end
    n_checks++; if (exit_code !== 32'h0) begin n_fail++; $display("[TB] FAIL mid reset exit_code: got %h expected 0", exit_code); end
    rst_n = 1'b1;
    req   = 1'b0;
    tick(g);
    bus_xfer(1'b0, 6'h14, 4'hF, 32'h0, rd, w);
    n_checks++; if (rd !== 32'h4) begin n_fail++; $display("[TB] FAIL post reset status: got %h expected 00000004", rd); end
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = 1'b0;
    we         = 1'b0;
    addr       = '0;
    be         = '0;
    wdata      = '0;
    char_ready = 1'b0;
    $display("[TB] starting tb_mmio_ctrl bench");
    test_reset();
    test_exit();
    test_print_hi();
    test_fifo_full();
    test_cycle();
    test_watchdog();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global timeout: got no finish expected finish within 1 ms");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
